// File: rtl/rf_scoreboard_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared defaults, types and constants for the scoreboarded
//               register file.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

  localparam int XLEN_D  = 32;
  localparam int NREGS_D = 32;
  localparam int AW_D    = $clog2(NREGS_D);

  typedef logic [AW_D-1:0]   reg_addr_t;
  typedef logic [XLEN_D-1:0] xdata_t;

  // Architectural zero register index
  localparam reg_addr_t REG_ZERO = '0;

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard_regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard_regfile_if
// Description : Decode / writeback / hazard-control bus of the scoreboarded
//               register file. master = pipeline side, slave = register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_scoreboard_regfile_if #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2,
  parameter int AW     = $clog2(NREGS)
);

  logic                         wr_en_i;
  logic [AW-1:0]                wr_addr_i;
  logic [XLEN-1:0]              wr_data_i;
  logic [NUM_RD-1:0][AW-1:0]    rd_addr_i;
  logic [NUM_RD-1:0][XLEN-1:0]  rd_data_o;
  logic [NUM_RD-1:0]            rd_busy_o;
  logic                         issue_en_i;
  logic [AW-1:0]                issue_rd_i;
  logic                         issue_ready_o;
  logic                         flush_i;
  logic [AW-1:0]                dbg_addr_i;
  logic [XLEN-1:0]              dbg_data_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, rd_addr_i,
    output issue_en_i, issue_rd_i, flush_i, dbg_addr_i,
    input  rd_data_o, rd_busy_o, issue_ready_o, dbg_data_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, rd_addr_i,
    input  issue_en_i, issue_rd_i, flush_i, dbg_addr_i,
    output rd_data_o, rd_busy_o, issue_ready_o, dbg_data_o
  );

endinterface
`default_nettype wire

// File: rtl/rf_scoreboard_regfile_pend_counters.sv
`default_nettype none
// ============================================================================
// Module      : rf_pend_counters
// Description : Per-register outstanding-write counters with issue/retire/
//               flush update, issue-ready and per-read-port busy generation.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_pend_counters #(
  parameter int NREGS  = 32,
  parameter int PEND_W = 2,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  wire logic                      clk_i,
  input  wire logic                      rst_ni,
  input  wire logic                      flush_i,
  input  wire logic                      issue_en_i,
  input  wire logic [AW-1:0]             issue_rd_i,
  input  wire logic                      wr_en_i,
  input  wire logic [AW-1:0]             wr_addr_i,
  input  wire logic [NUM_RD-1:0][AW-1:0] rd_addr_i,
  output logic                           issue_ready_o,
  output logic [NUM_RD-1:0]              rd_busy_o
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  logic [NREGS-1:0][PEND_W-1:0] cnt_q, cnt_d;

  // Saturated destinations refuse new issues; x0 is never tracked
  assign issue_ready_o = (issue_rd_i == '0) || (cnt_q[issue_rd_i] != CNT_MAX);

  // Next counter values: issue increments, retire decrements, flush clears all
  always_comb begin
    cnt_d = cnt_q;
    for (int r = 1; r < NREGS; r++) begin
      logic inc, dec;
      inc = issue_en_i && issue_ready_o && (issue_rd_i == AW'(r));
      dec = wr_en_i && (wr_addr_i == AW'(r)) && (cnt_q[r] != '0);
      if (inc && !dec) begin
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (dec && !inc) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
    if (flush_i) begin
      cnt_d = '0;
    end
    cnt_d[0] = '0;
  end

  // Counter state register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Busy per read port; a last pending write retiring this cycle is forwarded
  always_comb begin
    rd_busy_o = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      logic [PEND_W-1:0] c;
      c = cnt_q[rd_addr_i[p]];
      rd_busy_o[p] = (rd_addr_i[p] != '0) && (c != '0);
      if ((BYPASS != 0) && (c == CNT_ONE) && wr_en_i && (wr_addr_i == rd_addr_i[p])) begin
        rd_busy_o[p] = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rf_scoreboard_regfile.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard_regfile
// Description : Multi-port register file with optional write-to-read bypass
//               and an outstanding-write scoreboard. x0 reads as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard_regfile
  import rf_pkg::*;
#(
  parameter int XLEN   = XLEN_D,
  parameter int NREGS  = NREGS_D,
  parameter int NUM_RD = 2,
  parameter int PEND_W = 2,
  parameter int BYPASS = 1
) (
  input  wire logic               clk_i,
  input  wire logic               rst_ni,
  rf_scoreboard_regfile_if.slave  bus
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] ADDR_ZERO = AW'(REG_ZERO);

  logic [NREGS-1:0][XLEN-1:0]  regs_q;
  logic                        w_wr_hit;
  logic [NUM_RD-1:0][XLEN-1:0] w_rd_data;
  logic [NUM_RD-1:0]           w_rd_busy;
  logic                        w_issue_ready;

  assign w_wr_hit = bus.wr_en_i && (bus.wr_addr_i != ADDR_ZERO);

  // Register storage; x0 is never written so it stays zero after reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      regs_q <= '0;
    end else if (w_wr_hit) begin
      regs_q[bus.wr_addr_i] <= bus.wr_data_i;
    end
  end

  // Asynchronous read ports with optional same-cycle writeback forwarding
  always_comb begin
    w_rd_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (bus.rd_addr_i[p] != ADDR_ZERO) begin
        w_rd_data[p] = regs_q[bus.rd_addr_i[p]];
        if ((BYPASS != 0) && w_wr_hit && (bus.wr_addr_i == bus.rd_addr_i[p])) begin
          w_rd_data[p] = bus.wr_data_i;
        end
      end
    end
  end

  rf_pend_counters #(
    .NREGS  (NREGS),
    .PEND_W (PEND_W),
    .NUM_RD (NUM_RD),
    .BYPASS (BYPASS)
  ) u_pend (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (bus.flush_i),
    .issue_en_i    (bus.issue_en_i),
    .issue_rd_i    (bus.issue_rd_i),
    .wr_en_i       (bus.wr_en_i),
    .wr_addr_i     (bus.wr_addr_i),
    .rd_addr_i     (bus.rd_addr_i),
    .issue_ready_o (w_issue_ready),
    .rd_busy_o     (w_rd_busy)
  );

  // All outputs are held at zero while reset is asserted
  assign bus.rd_data_o     = rst_ni ? w_rd_data : '0;
  assign bus.rd_busy_o     = rst_ni ? w_rd_busy : '0;
  assign bus.issue_ready_o = rst_ni && w_issue_ready;
  assign bus.dbg_data_o    = rst_ni ? regs_q[bus.dbg_addr_i] : '0;

endmodule
`default_nettype wire
